// File: rtl/axi_burst_checker_pkg.sv
// Shared definitions for the passive AXI burst checker: error bit positions
// and the entry stored in each outstanding-burst length FIFO.
package axi_burst_checker_pkg;

    localparam int ERR_WLEN     = 0;
    localparam int ERR_RLEN     = 1;
    localparam int ERR_ORPHAN   = 2;
    localparam int ERR_OVERFLOW = 3;
    localparam int ERR_BORPHAN  = 4;
    localparam int ERR_W        = 5;

    // Entries are sized for the widest supported length field (LSIZE <= 16)
    localparam int LEN_W_MAX = 16;

    typedef struct packed {
        logic [LEN_W_MAX-1:0] len;
    } len_entry_t;

endpackage

// File: rtl/axi_burst_len_fifo.sv
// Outstanding-burst length FIFO. An empty FIFO presents an incoming push as its head
// (bypass), and a full FIFO accepts a push when the same cycle pops.
module axi_burst_len_fifo
    import axi_burst_checker_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int LSIZE = 8
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       push_i,
    input  len_entry_t push_data_i,
    input  logic       pop_i,
    output len_entry_t head_o,
    output logic       head_vld_o,
    output logic       overflow_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [LEN_W_MAX-1:0] LEN_MASK = LEN_W_MAX'((1 << LSIZE) - 1);

    len_entry_t    mem_q [DEPTH];
    logic [PW-1:0] rd_q, wr_q;
    logic [PW:0]   cnt_q, cnt_d;
    logic          empty, full, do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        empty      = (cnt_q == '0);
        full       = (cnt_q == (PW+1)'(DEPTH));
        head_vld_o = !empty || push_i;
        head_o     = empty ? push_data_i : mem_q[rd_q];
        head_o.len = head_o.len & LEN_MASK;
        do_pop     = pop_i && !empty;
        // A push consumed by the same-cycle bypass pop is never stored
        do_push    = push_i && !(empty && pop_i) && (!full || pop_i);
        overflow_o = push_i && full && !pop_i;
        cnt_d      = cnt_q;
        if (do_push && !do_pop)
            cnt_d = cnt_q + (PW+1)'(1);
        else if (do_pop && !do_push)
            cnt_d = cnt_q - (PW+1)'(1);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (do_push) wr_q <= ptr_inc(wr_q);
            if (do_pop)  rd_q <= ptr_inc(rd_q);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q] <= push_data_i;
    end

endmodule

// File: rtl/axi_burst_checker.sv
// Passive AXI burst-length checker with statistics. Define AXI_BURST_CHECKER_SUM_EN
// to fold every counted beat's data into the wr_sum/rd_sum XOR checksums.
module axi_burst_checker
    import axi_burst_checker_pkg::*;
#(
    parameter int ASIZE   = 32,
    parameter int DSIZE   = 64,
    parameter int IDSIZE  = 4,
    parameter int LSIZE   = 8,
    parameter int DEPTH   = 4,
    parameter int ID      = 0,
    parameter     LOCK_ID = "OFF",
    parameter int CNT_W   = 32
) (
    input  logic              axi_aclk,
    input  logic              axi_aresetn,
    input  logic              axi_awvalid,
    input  logic              axi_awready,
    input  logic [IDSIZE-1:0] axi_awid,
    input  logic [ASIZE-1:0]  axi_awaddr,
    input  logic [LSIZE-1:0]  axi_awlen,
    input  logic              axi_wvalid,
    input  logic              axi_wready,
    input  logic              axi_wlast,
    input  logic [DSIZE-1:0]  axi_wdata,
    input  logic              axi_bvalid,
    input  logic              axi_bready,
    input  logic              axi_arvalid,
    input  logic              axi_arready,
    input  logic [IDSIZE-1:0] axi_arid,
    input  logic [ASIZE-1:0]  axi_araddr,
    input  logic [LSIZE-1:0]  axi_arlen,
    input  logic              axi_rvalid,
    input  logic              axi_rready,
    input  logic              axi_rlast,
    input  logic [IDSIZE-1:0] axi_rid,
    input  logic [DSIZE-1:0]  axi_rdata,
    input  logic              clr_stats,
    output logic              wr_done,
    output logic              rd_done,
    output logic [CNT_W-1:0]  wr_burst_cnt,
    output logic [CNT_W-1:0]  rd_burst_cnt,
    output logic [CNT_W-1:0]  wr_beat_cnt,
    output logic [CNT_W-1:0]  rd_beat_cnt,
    output logic [ERR_W-1:0]  err,
    output logic [31:0]       wr_sum,
    output logic [31:0]       rd_sum
);

    localparam bit LOCK = (LOCK_ID == "ON");
    localparam int BW   = LSIZE + 1;
    localparam int CW   = LEN_W_MAX + 1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic             aw_hs, w_hs, ar_hs, r_hs, b_hs;
    len_entry_t       aw_entry, ar_entry, wf_head, rf_head;
    logic             wf_vld, rf_vld, wf_ovf, rf_ovf;
    logic [BW-1:0]    wbeat_q, wbeat_d, rbeat_q, rbeat_d, w_cnt, r_cnt;
    logic             w_pop, r_pop, w_len_err, r_len_err, b_orphan;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic [ERR_W-1:0] err_q, err_set;
    logic [CNT_W-1:0] wr_burst_q, rd_burst_q, wr_beat_q, rd_beat_q;
    logic             wr_done_q, rd_done_q;

    assign aw_hs = axi_awvalid && axi_awready && (!LOCK || axi_awid == IDSIZE'(ID));
    assign ar_hs = axi_arvalid && axi_arready && (!LOCK || axi_arid == IDSIZE'(ID));
    assign w_hs  = axi_wvalid && axi_wready;
    assign r_hs  = axi_rvalid && axi_rready && (!LOCK || axi_rid == IDSIZE'(ID));
    assign b_hs  = axi_bvalid && axi_bready;

    assign aw_entry = '{len: LEN_W_MAX'(axi_awlen)};
    assign ar_entry = '{len: LEN_W_MAX'(axi_arlen)};

    axi_burst_len_fifo #(.DEPTH(DEPTH), .LSIZE(LSIZE)) u_wr_fifo (
        .clk_i      (axi_aclk),
        .rst_ni     (axi_aresetn),
        .push_i     (aw_hs),
        .push_data_i(aw_entry),
        .pop_i      (w_pop),
        .head_o     (wf_head),
        .head_vld_o (wf_vld),
        .overflow_o (wf_ovf)
    );

    axi_burst_len_fifo #(.DEPTH(DEPTH), .LSIZE(LSIZE)) u_rd_fifo (
        .clk_i      (axi_aclk),
        .rst_ni     (axi_aresetn),
        .push_i     (ar_hs),
        .push_data_i(ar_entry),
        .pop_i      (r_pop),
        .head_o     (rf_head),
        .head_vld_o (rf_vld),
        .overflow_o (rf_ovf)
    );

    always_comb begin
        w_cnt     = (&wbeat_q) ? wbeat_q : wbeat_q + BW'(1);
        r_cnt     = (&rbeat_q) ? rbeat_q : rbeat_q + BW'(1);
        w_pop     = w_hs && wf_vld && axi_wlast;
        r_pop     = r_hs && rf_vld && axi_rlast;
        w_len_err = w_pop && (CW'(w_cnt) != CW'(wf_head.len) + CW'(1));
        r_len_err = r_pop && (CW'(r_cnt) != CW'(rf_head.len) + CW'(1));
        wbeat_d   = wbeat_q;
        rbeat_d   = rbeat_q;
        if (w_hs && wf_vld) wbeat_d = axi_wlast ? '0 : w_cnt;
        if (r_hs && rf_vld) rbeat_d = axi_rlast ? '0 : r_cnt;

        // B is checked against completions already registered, not this cycle's
        b_orphan = b_hs && (pend_q == '0);
        pend_d   = pend_q;
        if (w_pop && !(b_hs && !b_orphan))
            pend_d = sat_inc(pend_q);
        else if (!w_pop && b_hs && !b_orphan)
            pend_d = pend_q - CNT_W'(1);

        err_set               = '0;
        err_set[ERR_WLEN]     = w_len_err;
        err_set[ERR_RLEN]     = r_len_err;
        err_set[ERR_ORPHAN]   = (w_hs && !wf_vld) || (r_hs && !rf_vld);
        err_set[ERR_OVERFLOW] = wf_ovf || rf_ovf;
        err_set[ERR_BORPHAN]  = b_orphan;
    end

    always_ff @(posedge axi_aclk) begin
        if (!axi_aresetn) begin
            wbeat_q    <= '0;
            rbeat_q    <= '0;
            pend_q     <= '0;
            wr_done_q  <= 1'b0;
            rd_done_q  <= 1'b0;
            err_q      <= '0;
            wr_burst_q <= '0;
            rd_burst_q <= '0;
            wr_beat_q  <= '0;
            rd_beat_q  <= '0;
        end else begin
            wbeat_q   <= wbeat_d;
            rbeat_q   <= rbeat_d;
            pend_q    <= pend_d;
            wr_done_q <= w_pop;
            rd_done_q <= r_pop;
            // Clearing wins over any statistic update in the same cycle
            if (clr_stats) begin
                err_q      <= '0;
                wr_burst_q <= '0;
                rd_burst_q <= '0;
                wr_beat_q  <= '0;
                rd_beat_q  <= '0;
            end else begin
                err_q <= err_q | err_set;
                if (w_pop) wr_burst_q <= sat_inc(wr_burst_q);
                if (r_pop) rd_burst_q <= sat_inc(rd_burst_q);
                if (w_hs)  wr_beat_q  <= sat_inc(wr_beat_q);
                if (r_hs)  rd_beat_q  <= sat_inc(rd_beat_q);
            end
        end
    end

`ifdef AXI_BURST_CHECKER_SUM_EN
    logic [31:0] wr_sum_q, rd_sum_q;
    logic        unused_ok;

    function automatic logic [31:0] fold32(input logic [DSIZE-1:0] d);
        logic [31:0] f;
        f = '0;
        for (int i = 0; i < DSIZE / 32; i++) f = f ^ d[i*32 +: 32];
        return f;
    endfunction

    always_ff @(posedge axi_aclk) begin
        if (!axi_aresetn || clr_stats) begin
            wr_sum_q <= '0;
            rd_sum_q <= '0;
        end else begin
            if (w_hs) wr_sum_q <= wr_sum_q ^ fold32(axi_wdata);
            if (r_hs) rd_sum_q <= rd_sum_q ^ fold32(axi_rdata);
        end
    end

    assign wr_sum    = wr_sum_q;
    assign rd_sum    = rd_sum_q;
    assign unused_ok = ^{axi_awaddr, axi_araddr};
`else
    logic unused_ok;

    assign wr_sum    = '0;
    assign rd_sum    = '0;
    assign unused_ok = ^{axi_awaddr, axi_araddr, axi_wdata, axi_rdata};
`endif

    assign wr_done      = wr_done_q;
    assign rd_done      = rd_done_q;
    assign wr_burst_cnt = wr_burst_q;
    assign rd_burst_cnt = rd_burst_q;
    assign wr_beat_cnt  = wr_beat_q;
    assign rd_beat_cnt  = rd_beat_q;
    assign err          = err_q;

endmodule

// File: tb/tb_axi_burst_checker.sv
// Directed and randomized bench for axi_burst_checker, checked against a queue-based
// model of the outstanding bursts; a second instance runs with LOCK_ID "ON", ID 2.
module tb_axi_burst_checker;

    localparam int ASIZE = 32, DSIZE = 64, IDSIZE = 4, LSIZE = 8, DEPTH = 4;

    logic              axi_aclk = 1'b0;
    logic              axi_aresetn, clr_stats;
    logic              axi_awvalid, axi_awready, axi_wvalid, axi_wready, axi_wlast;
    logic              axi_bvalid, axi_bready, axi_arvalid, axi_arready;
    logic              axi_rvalid, axi_rready, axi_rlast;
    logic [IDSIZE-1:0] axi_awid, axi_arid, axi_rid;
    logic [ASIZE-1:0]  axi_awaddr, axi_araddr;
    logic [LSIZE-1:0]  axi_awlen, axi_arlen;
    logic [DSIZE-1:0]  axi_wdata, axi_rdata;

    logic        wr_done, rd_done, lk_wr_done, lk_rd_done;
    logic [31:0] wr_burst_cnt, rd_burst_cnt, wr_beat_cnt, rd_beat_cnt, wr_sum, rd_sum;
    logic [31:0] lk_wr_burst_cnt, lk_rd_burst_cnt, lk_wr_beat_cnt, lk_rd_beat_cnt;
    logic [31:0] lk_wr_sum, lk_rd_sum;
    logic [4:0]  err, lk_err;

    axi_burst_checker u_dut (
        .axi_aclk(axi_aclk), .axi_aresetn(axi_aresetn),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awid(axi_awid),
        .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wlast(axi_wlast),
        .axi_wdata(axi_wdata), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_arid(axi_arid),
        .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rlast(axi_rlast),
        .axi_rid(axi_rid), .axi_rdata(axi_rdata), .clr_stats(clr_stats),
        .wr_done(wr_done), .rd_done(rd_done),
        .wr_burst_cnt(wr_burst_cnt), .rd_burst_cnt(rd_burst_cnt),
        .wr_beat_cnt(wr_beat_cnt), .rd_beat_cnt(rd_beat_cnt),
        .err(err), .wr_sum(wr_sum), .rd_sum(rd_sum)
    );

    axi_burst_checker #(.ID(2), .LOCK_ID("ON")) u_lock (
        .axi_aclk(axi_aclk), .axi_aresetn(axi_aresetn),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awid(axi_awid),
        .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wlast(axi_wlast),
        .axi_wdata(axi_wdata), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_arid(axi_arid),
        .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rlast(axi_rlast),
        .axi_rid(axi_rid), .axi_rdata(axi_rdata), .clr_stats(clr_stats),
        .wr_done(lk_wr_done), .rd_done(lk_rd_done),
        .wr_burst_cnt(lk_wr_burst_cnt), .rd_burst_cnt(lk_rd_burst_cnt),
        .wr_beat_cnt(lk_wr_beat_cnt), .rd_beat_cnt(lk_rd_beat_cnt),
        .err(lk_err), .wr_sum(lk_wr_sum), .rd_sum(lk_rd_sum)
    );

    always #5 axi_aclk = ~axi_aclk;

    int checks = 0, errors = 0;
    int wdone_n, rdone_n, lk_rdone_n;

    // Reference model: lengths of accepted-but-unfinished bursts, in order
    int unsigned m_wq[$], m_rq[$];
    int          m_wcnt, m_rcnt, m_pend;
    logic [31:0] e_wbc, e_rbc, e_wbt, e_rbt, e_wsum, e_rsum;
    logic [4:0]  e_err;
    logic        e_wdone, e_rdone;

    function automatic logic [31:0] sat(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    function automatic logic [31:0] fold(input logic [63:0] d);
        return d[31:0] ^ d[63:32];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit          aw, w, ar, r, b, wpop, rpop;
        int unsigned head, tmp, wsz, rsz;
        aw = axi_awvalid && axi_awready;
        w  = axi_wvalid && axi_wready;
        ar = axi_arvalid && axi_arready;
        r  = axi_rvalid && axi_rready;
        b  = axi_bvalid && axi_bready;
        wpop = 0; rpop = 0;
        if (!axi_aresetn) begin
            m_wq.delete(); m_rq.delete();
            m_wcnt = 0; m_rcnt = 0; m_pend = 0;
            e_wbc = '0; e_rbc = '0; e_wbt = '0; e_rbt = '0; e_wsum = '0; e_rsum = '0;
            e_err = '0; e_wdone = 0; e_rdone = 0;
            return;
        end
        wsz = m_wq.size(); rsz = m_rq.size();
        if (w) begin
            e_wbt = sat(e_wbt);
`ifdef AXI_BURST_CHECKER_SUM_EN
            e_wsum = e_wsum ^ fold(axi_wdata);
`endif
            if (wsz == 0 && !aw) e_err[2] = 1'b1;
            else begin
                head = (wsz != 0) ? m_wq[0] : 32'(axi_awlen);
                m_wcnt++;
                if (axi_wlast) begin
                    wpop = 1;
                    if (m_wcnt != head + 1) e_err[0] = 1'b1;
                    e_wbc = sat(e_wbc);
                    m_wcnt = 0;
                end
            end
        end
        if (r) begin
            e_rbt = sat(e_rbt);
`ifdef AXI_BURST_CHECKER_SUM_EN
            e_rsum = e_rsum ^ fold(axi_rdata);
`endif
            if (rsz == 0 && !ar) e_err[2] = 1'b1;
            else begin
                head = (rsz != 0) ? m_rq[0] : 32'(axi_arlen);
                m_rcnt++;
                if (axi_rlast) begin
                    rpop = 1;
                    if (m_rcnt != head + 1) e_err[1] = 1'b1;
                    e_rbc = sat(e_rbc);
                    m_rcnt = 0;
                end
            end
        end
        if (wpop && wsz != 0) tmp = m_wq.pop_front();
        if (aw && !(wpop && wsz == 0)) begin
            if (wsz == DEPTH && !wpop) e_err[3] = 1'b1;
            else m_wq.push_back(32'(axi_awlen));
        end
        if (rpop && rsz != 0) tmp = m_rq.pop_front();
        if (ar && !(rpop && rsz == 0)) begin
            if (rsz == DEPTH && !rpop) e_err[3] = 1'b1;
            else m_rq.push_back(32'(axi_arlen));
        end
        if (b) begin
            if (m_pend == 0) e_err[4] = 1'b1;
            else m_pend--;
        end
        if (wpop) m_pend++;
        e_wdone = wpop;
        e_rdone = rpop;
        if (clr_stats) begin
            e_wbc = '0; e_rbc = '0; e_wbt = '0; e_rbt = '0; e_wsum = '0; e_rsum = '0;
            e_err = '0;
        end
    endtask

    task automatic step();
        model_step();
        @(posedge axi_aclk);
        #1;
        wdone_n += int'(wr_done);
        rdone_n += int'(rd_done);
        lk_rdone_n += int'(lk_rd_done);
        chk("wr_done", wr_done, e_wdone);
        chk("rd_done", rd_done, e_rdone);
        chk("wr_burst_cnt", wr_burst_cnt, e_wbc);
        chk("rd_burst_cnt", rd_burst_cnt, e_rbc);
        chk("wr_beat_cnt", wr_beat_cnt, e_wbt);
        chk("rd_beat_cnt", rd_beat_cnt, e_rbt);
        chk("err", err, e_err);
        chk("wr_sum", wr_sum, e_wsum);
        chk("rd_sum", rd_sum, e_rsum);
    endtask

    task automatic idle();
        axi_awvalid = 0; axi_awready = 0; axi_wvalid = 0; axi_wready = 0; axi_wlast = 0;
        axi_bvalid = 0; axi_bready = 0; axi_arvalid = 0; axi_arready = 0;
        axi_rvalid = 0; axi_rready = 0; axi_rlast = 0; clr_stats = 0;
    endtask

    task automatic do_reset();
        idle(); axi_aresetn = 0; step(); axi_aresetn = 1;
    endtask

    task automatic aw_tx(input int len);
        axi_awvalid = 1; axi_awready = 1; axi_awlen = LSIZE'(len);
        axi_awaddr = $urandom; step(); axi_awvalid = 0;
    endtask

    task automatic w_tx(input bit last);
        axi_wvalid = 1; axi_wready = 1; axi_wlast = last; axi_wdata = {$urandom, $urandom};
        step(); axi_wvalid = 0; axi_wlast = 0;
    endtask

    task automatic w_burst(input int n);
        for (int i = 1; i <= n; i++) w_tx(i == n);
    endtask

    task automatic ar_tx(input int len, input int id);
        axi_arvalid = 1; axi_arready = 1; axi_arlen = LSIZE'(len); axi_arid = IDSIZE'(id);
        axi_araddr = $urandom; step(); axi_arvalid = 0;
    endtask

    task automatic r_tx(input bit last, input int id);
        axi_rvalid = 1; axi_rready = 1; axi_rlast = last; axi_rid = IDSIZE'(id);
        axi_rdata = {$urandom, $urandom}; step(); axi_rvalid = 0; axi_rlast = 0;
    endtask

    task automatic b_tx();
        axi_bvalid = 1; axi_bready = 1; step(); axi_bvalid = 0; axi_bready = 0;
    endtask

    initial begin
        axi_awid = '0; axi_arid = '0; axi_rid = '0; axi_awlen = '0; axi_arlen = '0;
        axi_awaddr = '0; axi_araddr = '0; axi_wdata = '0; axi_rdata = '0;
        wdone_n = 0; rdone_n = 0; lk_rdone_n = 0;
        do_reset(); do_reset();
        chk("reset_err", err, 5'd0);
        chk("reset_wr_burst", wr_burst_cnt, 32'd0);

        // Clean write burst
        wdone_n = 0;
        aw_tx(3); w_burst(4); idle(); step();
        chk("wr4_done_pulses", wdone_n, 1);
        chk("wr4_burst_cnt", wr_burst_cnt, 32'd1);
        chk("wr4_beat_cnt", wr_beat_cnt, 32'd4);
        chk("wr4_err", err, 5'd0);
        b_tx();
        chk("wr4_b_ok", err, 5'd0);

        // Short read burst
        ar_tx(7, 0);
        for (int i = 1; i <= 6; i++) r_tx(i == 6, 0);
        chk("rd_short_err", err[1], 1'b1);
        chk("rd_short_burst", rd_burst_cnt, 32'd1);
        clr_stats = 1; step(); clr_stats = 0;
        chk("clr_err", err, 5'd0);
        chk("clr_rd_beat", rd_beat_cnt, 32'd0);

        // Overflow: the fifth AW is dropped, four entries remain
        for (int i = 0; i < 5; i++) aw_tx(i % 4);
        chk("ovf_err", err[3], 1'b1);
        clr_stats = 1; step(); clr_stats = 0;
        wdone_n = 0;
        for (int i = 1; i <= 4; i++) w_burst(i);
        step();
        chk("ovf_drain_pulses", wdone_n, 4);
        chk("ovf_drain_err", err, 5'd0);
        w_tx(1);
        chk("ovf_only_four", err, 5'b00100);
        clr_stats = 1; step(); clr_stats = 0;

        // Bypass on empty FIFO, then simultaneous push and pop on full FIFO
        axi_awvalid = 1; axi_awready = 1; axi_awlen = '0;
        w_tx(1); axi_awvalid = 0; step();
        chk("bypass_err", err, 5'd0);
        chk("bypass_burst", wr_burst_cnt, 32'd1);
        for (int i = 0; i < 4; i++) aw_tx(0);
        axi_awvalid = 1; axi_awready = 1; axi_awlen = '0;
        w_tx(1); axi_awvalid = 0;
        chk("full_pushpop_err", err, 5'd0);
        for (int i = 0; i < 4; i++) w_tx(1);
        chk("full_drain_err", err, 5'd0);
        chk("full_drain_burst", wr_burst_cnt, 32'd6);

        // Orphan W beat, then orphan B
        do_reset();
        w_tx(1);
        chk("orphan_w", err, 5'b00100);
        b_tx();
        chk("orphan_b", err, 5'b10100);

        // Reset in the middle of a burst
        do_reset();
        aw_tx(3); w_tx(0); w_tx(0);
        do_reset();
        chk("midrst_err", err, 5'd0);
        chk("midrst_beat", wr_beat_cnt, 32'd0);
        chk("midrst_wr_done", wr_done, 1'b0);
        aw_tx(3); w_burst(4); step();
        chk("midrst_after_err", err, 5'd0);
        chk("midrst_after_burst", wr_burst_cnt, 32'd1);

        // ID filter on the locked instance
        do_reset();
        lk_rdone_n = 0;
        ar_tx(1, 1); r_tx(0, 1); r_tx(1, 1); step();
        chk("lock_skip_burst", lk_rd_burst_cnt, 32'd0);
        chk("lock_skip_beat", lk_rd_beat_cnt, 32'd0);
        chk("lock_skip_err", lk_err, 5'd0);
        chk("lock_skip_done", lk_rdone_n, 0);
        chk("lock_skip_wsum", lk_wr_sum, 32'd0);
        chk("open_rd_burst", rd_burst_cnt, 32'd1);
        ar_tx(1, 2); r_tx(0, 2); r_tx(1, 2); step();
        chk("lock_match_burst", lk_rd_burst_cnt, 32'd1);
        chk("lock_match_beat", lk_rd_beat_cnt, 32'd2);
        chk("lock_match_err", lk_err, 5'd0);
        chk("lock_match_done", lk_rdone_n, 1);

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            axi_awvalid = ($urandom_range(3) == 0); axi_awready = 1'($urandom_range(1));
            axi_awlen = LSIZE'($urandom_range(3)); axi_awid = IDSIZE'($urandom_range(3));
            axi_wvalid = 1'($urandom_range(1)); axi_wready = 1'($urandom_range(1));
            axi_wlast = ($urandom_range(2) == 0); axi_wdata = {$urandom, $urandom};
            axi_arvalid = ($urandom_range(3) == 0); axi_arready = 1'($urandom_range(1));
            axi_arlen = LSIZE'($urandom_range(3)); axi_arid = IDSIZE'($urandom_range(3));
            axi_rvalid = 1'($urandom_range(1)); axi_rready = 1'($urandom_range(1));
            axi_rlast = ($urandom_range(2) == 0); axi_rdata = {$urandom, $urandom};
            axi_rid = IDSIZE'($urandom_range(3));
            axi_bvalid = ($urandom_range(5) == 0); axi_bready = 1'($urandom_range(1));
            clr_stats = ($urandom_range(99) == 0);
            step();
        end
        idle(); step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
